// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard scan-code sequencer: scan constants,
// fetch state encoding, the event record and modifier bit positions.
package kbd_pkg;

  // Set-2 prefix and modifier scan codes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Bit positions inside the 4-bit modifier vector {caps, alt, ctrl, shift}
  localparam int MOD_SHIFT = 0;
  localparam int MOD_CTRL  = 1;
  localparam int MOD_ALT   = 2;
  localparam int MOD_CAPS  = 3;

  // Bit positions inside the per-side modifier key register
  localparam int SD_LSHIFT = 0;
  localparam int SD_RSHIFT = 1;
  localparam int SD_LCTRL  = 2;
  localparam int SD_RCTRL  = 3;
  localparam int SD_LALT   = 4;
  localparam int SD_RALT   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } kbd_event_t;

  // Keyboard status/ack bytes that never form a key event
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // Collapse per-side key bits plus caps latch into {caps, alt, ctrl, shift}
  function automatic logic [3:0] pack_mods(input logic [5:0] side, input logic caps);
    logic [3:0] m;
    m            = '0;
    m[MOD_SHIFT] = side[SD_LSHIFT] | side[SD_RSHIFT];
    m[MOD_CTRL]  = side[SD_LCTRL]  | side[SD_RCTRL];
    m[MOD_ALT]   = side[SD_LALT]   | side[SD_RALT];
    m[MOD_CAPS]  = caps;
    return m;
  endfunction

endpackage

// File: rtl/kbd_scan_ctrl_evq.sv
// Small show-ahead FIFO of keyboard events. Head entry is presented on o_data
// whenever o_valid is high; push and pop may happen in the same cycle.
module kbd_evq
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_clrn,
  input  logic        i_push,
  input  kbd_event_t  i_data,
  input  logic        i_pop,
  output kbd_event_t  o_data,
  output logic        o_valid,
  output logic [AW:0] o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  kbd_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A push into a full queue is only taken when a pop frees a slot that cycle
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  // Storage, pointers and occupancy count
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Drains the PS/2 receiver FIFO one byte per three cycles, parses set-2
// prefixes, tracks modifiers, filters typematic repeats and queues whole
// make/break events.
//
// Handshake: an event transfers on every rising clk edge where
// ev_valid && ev_ready; ev_* hold steady while ev_valid && !ev_ready.
// Receiver side: a byte is consumed by a single-cycle low on nextdata_n.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int EV_DEPTH      = 4,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         ready,
  input  logic [7:0]   data,
  input  logic         overflow,
  output logic         nextdata_n,
  output logic         ev_valid,
  input  logic         ev_ready,
  output logic [7:0]   ev_code,
  output logic         ev_ext,
  output logic         ev_brk,
  output logic [3:0]   ev_mods,
  output logic [3:0]   mods,
  output logic         ovf_err,
  output fetch_state_t dbg_state
);

  localparam int CW = $clog2(EV_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(EV_DEPTH);

  // Fetch FSM
  fetch_state_t r_state, w_state_n;
  logic         r_nextdata_n, w_nextdata_n_n;
  logic         w_load;
  logic [7:0]   r_byte;

  // Decoder context and the candidate event formed in S_POP
  logic         r_ext, w_ext_n;
  logic         r_brk, w_brk_n;
  logic [2:0]   r_skip, w_skip_n;
  logic         r_cand_v, w_cand_v_n;
  logic [7:0]   r_cand_code;
  logic         r_cand_ext, w_cand_ext_n;
  logic         r_cand_brk, w_cand_brk_n;

  // Repeat filter, modifiers, queue interface
  logic         r_held_v, w_held_v_n;
  logic         r_held_ext, w_held_ext_n;
  logic [7:0]   r_held_code, w_held_code_n;
  logic         w_match, w_drop, w_push, w_make;
  logic [5:0]   r_side, w_side_n;
  logic         r_caps, w_caps_n;
  logic [3:0]   w_mods_n;
  kbd_event_t   w_ev, w_head;
  logic [CW-1:0] w_q_count;
  logic         r_ovf;

  // Fetch state register, pop strobe and byte latch
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_nextdata_n <= 1'b1;
      r_byte       <= '0;
    end else begin
      r_state      <= w_state_n;
      r_nextdata_n <= w_nextdata_n_n;
      if (w_load) r_byte <= data;
    end
  end

  // Fetch next-state: pop only while the queue has room, so no event is lost
  always_comb begin
    w_state_n      = r_state;
    w_nextdata_n_n = 1'b1;
    w_load         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ready && (w_q_count != FULL_CNT)) begin
          w_load         = 1'b1;
          w_nextdata_n_n = 1'b0;
          w_state_n      = S_POP;
        end
      end
      S_POP:   w_state_n = S_GAP;
      S_GAP:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Byte decoder: prefixes update context, other codes form a candidate event
  always_comb begin
    w_ext_n      = r_ext;
    w_brk_n      = r_brk;
    w_skip_n     = r_skip;
    w_cand_v_n   = 1'b0;
    w_cand_ext_n = r_ext;
    w_cand_brk_n = r_brk;
    if (r_state == S_POP) begin
      if (r_skip != 3'd0) begin
        w_skip_n = r_skip - 3'd1;
      end else if (r_byte == SC_PAUSE) begin
        // Pause is reported once; its 7 trailing bytes are swallowed
        w_skip_n     = 3'd7;
        w_cand_v_n   = 1'b1;
        w_cand_ext_n = 1'b0;
        w_cand_brk_n = 1'b0;
      end else if (r_byte == SC_EXT) begin
        w_ext_n = 1'b1;
      end else if (r_byte == SC_BRK) begin
        w_brk_n = 1'b1;
      end else if (is_status_byte(r_byte)) begin
        w_ext_n = 1'b0;
        w_brk_n = 1'b0;
      end else begin
        w_cand_v_n = 1'b1;
        w_ext_n    = 1'b0;
        w_brk_n    = 1'b0;
      end
    end
    if (overflow) begin
      w_ext_n  = 1'b0;
      w_brk_n  = 1'b0;
      w_skip_n = 3'd0;
    end
  end

  // Decoder context and candidate registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_skip      <= 3'd0;
      r_cand_v    <= 1'b0;
      r_cand_code <= '0;
      r_cand_ext  <= 1'b0;
      r_cand_brk  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ext       <= w_ext_n;
      r_brk       <= w_brk_n;
      r_skip      <= w_skip_n;
      r_cand_v    <= w_cand_v_n;
      r_cand_code <= r_byte;
      r_cand_ext  <= w_cand_ext_n;
      r_cand_brk  <= w_cand_brk_n;
      r_ovf       <= r_ovf | overflow;
    end
  end

  // Repeat filter: a make of the key already held is a typematic repeat
  always_comb begin
    w_match       = r_held_v && (r_held_ext == r_cand_ext) && (r_held_code == r_cand_code);
    w_drop        = FILTER_REPEAT && !r_cand_brk && w_match;
    w_push        = r_cand_v && !w_drop;
    w_held_v_n    = r_held_v;
    w_held_ext_n  = r_held_ext;
    w_held_code_n = r_held_code;
    if (FILTER_REPEAT && r_cand_v) begin
      if (r_cand_brk) begin
        if (w_match) w_held_v_n = 1'b0;
      end else if (!w_match) begin
        w_held_v_n    = 1'b1;
        w_held_ext_n  = r_cand_ext;
        w_held_code_n = r_cand_code;
      end
    end
  end

  // Modifier update for the event being pushed; snapshot reflects the update
  always_comb begin
    w_side_n = r_side;
    w_caps_n = r_caps;
    w_make   = !r_cand_brk;
    if (w_push) begin
      if (!r_cand_ext && (r_cand_code == SC_LSHIFT)) w_side_n[SD_LSHIFT] = w_make;
      if (!r_cand_ext && (r_cand_code == SC_RSHIFT)) w_side_n[SD_RSHIFT] = w_make;
      if (r_cand_code == SC_CTRL) begin
        if (r_cand_ext) w_side_n[SD_RCTRL] = w_make;
        else            w_side_n[SD_LCTRL] = w_make;
      end
      if (r_cand_code == SC_ALT) begin
        if (r_cand_ext) w_side_n[SD_RALT] = w_make;
        else            w_side_n[SD_LALT] = w_make;
      end
      if (!r_cand_ext && (r_cand_code == SC_CAPS) && w_make) w_caps_n = !r_caps;
    end
    w_mods_n = pack_mods(w_side_n, w_caps_n);
    w_ev     = '{code: r_cand_code, ext: r_cand_ext, brk: r_cand_brk, mods: w_mods_n};
  end

  // Held-key and modifier state registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_held_v    <= 1'b0;
      r_held_ext  <= 1'b0;
      r_held_code <= '0;
      r_side      <= '0;
      r_caps      <= 1'b0;
    end else begin
      r_held_v    <= w_held_v_n;
      r_held_ext  <= w_held_ext_n;
      r_held_code <= w_held_code_n;
      r_side      <= w_side_n;
      r_caps      <= w_caps_n;
    end
  end

  kbd_evq #(.DEPTH(EV_DEPTH)) u_evq (
    .i_clk   (clk),
    .i_clrn  (clrn),
    .i_push  (w_push),
    .i_data  (w_ev),
    .i_pop   (ev_ready),
    .o_data  (w_head),
    .o_valid (ev_valid),
    .o_count (w_q_count)
  );

  assign nextdata_n = r_nextdata_n;
  assign ev_code    = w_head.code;
  assign ev_ext     = w_head.ext;
  assign ev_brk     = w_head.brk;
  assign ev_mods    = w_head.mods;
  assign mods       = pack_mods(r_side, r_caps);
  assign ovf_err    = r_ovf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: a receiver-FIFO model feeds both a filtering and a
// non-filtering instance; events are collected and checked against vectors.
module tb_kbd_scan_ctrl;
  import kbd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;
  logic       ev_ready = 1'b1;

  logic         nextdata_n, ev_valid, ev_ext, ev_brk, ovf_err;
  logic [7:0]   ev_code;
  logic [3:0]   ev_mods, mods;
  fetch_state_t dbg_state;

  logic         nf_nextdata_n, nf_ev_valid, nf_ev_ext, nf_ev_brk, nf_ovf_err;
  logic [7:0]   nf_ev_code;
  logic [3:0]   nf_ev_mods, nf_mods;
  fetch_state_t nf_dbg_state;

  kbd_scan_ctrl #(.EV_DEPTH(4), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_mods(ev_mods),
    .mods(mods), .ovf_err(ovf_err), .dbg_state(dbg_state)
  );

  kbd_scan_ctrl #(.EV_DEPTH(4), .FILTER_REPEAT(1'b0)) dut_nf (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nf_nextdata_n), .ev_valid(nf_ev_valid), .ev_ready(ev_ready),
    .ev_code(nf_ev_code), .ev_ext(nf_ev_ext), .ev_brk(nf_ev_brk), .ev_mods(nf_ev_mods),
    .mods(nf_mods), .ovf_err(nf_ovf_err), .dbg_state(nf_dbg_state)
  );

  // ---------------- receiver FIFO model ----------------
  logic [7:0] rx_buf [1024];
  int rx_wr = 0;
  int rx_rd = 0;
  int pulses = 0;

  always @(negedge clk) begin
    if (clrn && !nextdata_n) begin
      pulses = pulses + 1;
      if (rx_rd != rx_wr) rx_rd = rx_rd + 1;
    end
    ready = (rx_rd != rx_wr);
    data  = ready ? rx_buf[rx_rd] : 8'h00;
  end

  // ---------------- event collector ----------------
  logic [13:0] got_buf [1024];
  logic [13:0] got_nf_buf [1024];
  int got_n = 0;
  int got_nf_n = 0;

  always @(negedge clk) begin
    if (clrn && ev_valid && ev_ready) begin
      got_buf[got_n] = {ev_code, ev_ext, ev_brk, ev_mods};
      got_n = got_n + 1;
    end
    if (clrn && nf_ev_valid && ev_ready) begin
      got_nf_buf[got_nf_n] = {nf_ev_code, nf_ev_ext, nf_ev_brk, nf_ev_mods};
      got_nf_n = got_nf_n + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [13:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] mk_ev(input logic [7:0] c, input logic e,
                                       input logic k, input logic [3:0] m);
    return {c, e, k, m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    rx_buf[rx_wr] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clrn = 1'b0;
    overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((rx_rd != rx_wr) && (k < 400)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 400) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected<400", k);
    end
    repeat (12) @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  b [8];
    int          nb;
    int          nev;
    logic [13:0] ev [4];
    int          nev_nf;
    logic [3:0]  mods_end;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int g0, n0, p0;

    vecs[0] = '{b:'{8'h1C,8'hF0,8'h1C,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:3, nev:2,
                ev:'{mk_ev(8'h1C,1'b0,1'b0,4'h0), mk_ev(8'h1C,1'b0,1'b1,4'h0), 14'h0, 14'h0},
                nev_nf:2, mods_end:4'h0};
    vecs[1] = '{b:'{8'hE0,8'hF0,8'h75,8'h00,8'h00,8'h00,8'h00,8'h00}, nb:3, nev:1,
                ev:'{mk_ev(8'h75,1'b1,1'b1,4'h0), 14'h0, 14'h0, 14'h0},
                nev_nf:1, mods_end:4'h0};
    vecs[2] = '{b:'{8'h1C,8'h1C,8'h1C,8'hF0,8'h1C,8'h00,8'h00,8'h00}, nb:5, nev:2,
                ev:'{mk_ev(8'h1C,1'b0,1'b0,4'h0), mk_ev(8'h1C,1'b0,1'b1,4'h0), 14'h0, 14'h0},
                nev_nf:4, mods_end:4'h0};
    vecs[3] = '{b:'{8'hE1,8'h14,8'h77,8'hE1,8'hF0,8'h14,8'hF0,8'h77}, nb:8, nev:1,
                ev:'{mk_ev(8'hE1,1'b0,1'b0,4'h0), 14'h0, 14'h0, 14'h0},
                nev_nf:1, mods_end:4'h0};
    vecs[4] = '{b:'{8'h12,8'h58,8'hF0,8'h58,8'h58,8'h00,8'h00,8'h00}, nb:5, nev:4,
                ev:'{mk_ev(8'h12,1'b0,1'b0,4'b0001), mk_ev(8'h58,1'b0,1'b0,4'b1001),
                     mk_ev(8'h58,1'b0,1'b1,4'b1001), mk_ev(8'h58,1'b0,1'b0,4'b0001)},
                nev_nf:4, mods_end:4'b0001};
    vecs[5] = '{b:'{8'hE0,8'h14,8'hE0,8'h11,8'hE0,8'hF0,8'h14,8'h00}, nb:7, nev:3,
                ev:'{mk_ev(8'h14,1'b1,1'b0,4'b0010), mk_ev(8'h11,1'b1,1'b0,4'b0110),
                     mk_ev(8'h14,1'b1,1'b1,4'b0100), 14'h0},
                nev_nf:3, mods_end:4'b0100};
    vecs[6] = '{b:'{8'h12,8'h59,8'hF0,8'h12,8'h00,8'h00,8'h00,8'h00}, nb:4, nev:3,
                ev:'{mk_ev(8'h12,1'b0,1'b0,4'b0001), mk_ev(8'h59,1'b0,1'b0,4'b0001),
                     mk_ev(8'h12,1'b0,1'b1,4'b0001), 14'h0},
                nev_nf:3, mods_end:4'b0001};
    vecs[7] = '{b:'{8'hE0,8'hAA,8'hFA,8'h1C,8'h00,8'h00,8'h00,8'h00}, nb:4, nev:1,
                ev:'{mk_ev(8'h1C,1'b0,1'b0,4'h0), 14'h0, 14'h0, 14'h0},
                nev_nf:1, mods_end:4'h0};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_ev_valid",   32'(ev_valid),   32'd0);
    chk("rst_ev_fields",  32'({ev_code, ev_ext, ev_brk, ev_mods}), 32'd0);
    chk("rst_mods",       32'(mods),       32'd0);
    chk("rst_ovf_err",    32'(ovf_err),    32'd0);
    chk("rst_state",      32'(dbg_state),  32'(S_IDLE));
    @(posedge clk); #1 clrn = 1'b1;

    // ---- latency: ready at edge N, strobe low after N, ev_valid after N+2 ----
    ev_ready = 1'b1;
    g0 = got_n;
    @(posedge clk); send(8'h2C);
    @(negedge clk);
    @(negedge clk);
    chk("lat_strobe_low",  32'(nextdata_n), 32'd0);
    chk("lat_valid_n1",    32'(ev_valid),   32'd0);
    @(negedge clk);
    chk("lat_strobe_high", 32'(nextdata_n), 32'd1);
    chk("lat_valid_n2",    32'(ev_valid),   32'd0);
    @(negedge clk);
    chk("lat_valid_n3",    32'(ev_valid),   32'd1);
    drain();
    chk("lat_count", 32'(got_n - g0), 32'd1);
    chk("lat_event", 32'(got_buf[g0]), 32'(mk_ev(8'h2C, 1'b0, 1'b0, 4'h0)));

    // ---- table-driven vectors ----
    for (int v = 0; v < 8; v++) begin
      do_reset();
      g0 = got_n; n0 = got_nf_n; p0 = pulses;
      for (int i = 0; i < vecs[v].nb; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send(vecs[v].b[i]);
      end
      drain();
      chk($sformatf("v%0d_count", v), 32'(got_n - g0), 32'(vecs[v].nev));
      chk($sformatf("v%0d_nf_count", v), 32'(got_nf_n - n0), 32'(vecs[v].nev_nf));
      chk($sformatf("v%0d_pulses", v), 32'(pulses - p0), 32'(vecs[v].nb));
      chk($sformatf("v%0d_mods", v), 32'(mods), 32'(vecs[v].mods_end));
      for (int i = 0; i < vecs[v].nev; i++) exp_q.push_back(vecs[v].ev[i]);
      for (int i = 0; i < vecs[v].nev; i++) begin
        logic [13:0] e;
        e = exp_q.pop_front();
        chk($sformatf("v%0d_ev%0d", v, i), 32'(got_buf[g0 + i]), 32'(e));
      end
    end

    // ---- backpressure: six makes, queue holds four ----
    do_reset();
    ev_ready = 1'b0;
    g0 = got_n; p0 = pulses;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
    repeat (30) @(negedge clk);
    chk("bp_pulses_30", 32'(pulses - p0), 32'd4);
    chk("bp_head_30",   32'({ev_valid, ev_code, ev_ext, ev_brk}), 32'({1'b1, 8'h15, 1'b0, 1'b0}));
    repeat (30) @(negedge clk);
    chk("bp_pulses_60", 32'(pulses - p0), 32'd4);
    chk("bp_rx_left",   32'(rx_wr - rx_rd), 32'd2);
    chk("bp_strobe",    32'(nextdata_n), 32'd1);
    chk("bp_head_60",   32'({ev_valid, ev_code, ev_ext, ev_brk}), 32'({1'b1, 8'h15, 1'b0, 1'b0}));
    @(posedge clk); #1 ev_ready = 1'b1;
    drain();
    chk("bp_count", 32'(got_n - g0), 32'd6);
    exp_q.push_back(mk_ev(8'h15, 1'b0, 1'b0, 4'h0));
    exp_q.push_back(mk_ev(8'h1D, 1'b0, 1'b0, 4'h0));
    exp_q.push_back(mk_ev(8'h24, 1'b0, 1'b0, 4'h0));
    exp_q.push_back(mk_ev(8'h2D, 1'b0, 1'b0, 4'h0));
    exp_q.push_back(mk_ev(8'h2C, 1'b0, 1'b0, 4'h0));
    exp_q.push_back(mk_ev(8'h35, 1'b0, 1'b0, 4'h0));
    for (int i = 0; i < 6; i++) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      chk($sformatf("bp_ev%0d", i), 32'(got_buf[g0 + i]), 32'(e));
    end

    // ---- reset after E0 discards the prefix ----
    do_reset();
    send(8'hE0);
    drain();
    do_reset();
    g0 = got_n;
    send(8'h1C);
    drain();
    chk("rstE0_count", 32'(got_n - g0), 32'd1);
    chk("rstE0_event", 32'(got_buf[g0]), 32'(mk_ev(8'h1C, 1'b0, 1'b0, 4'h0)));

    // ---- reset mid-pause discards the skip counter ----
    do_reset();
    send(8'hE1); send(8'h14);
    drain();
    do_reset();
    g0 = got_n;
    send(8'h1C);
    drain();
    chk("rstE1_count", 32'(got_n - g0), 32'd1);
    chk("rstE1_event", 32'(got_buf[g0]), 32'(mk_ev(8'h1C, 1'b0, 1'b0, 4'h0)));

    // ---- overflow: sticky flag, prefix cleared ----
    do_reset();
    send(8'hE0);
    drain();
    @(posedge clk); #1 overflow = 1'b1;
    @(posedge clk); #1 overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    g0 = got_n;
    send(8'h1C);
    drain();
    chk("ovf_event", 32'(got_buf[g0]), 32'(mk_ev(8'h1C, 1'b0, 1'b0, 4'h0)));
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", 32'(ovf_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
